// File: rtl/fetch_redirect_unit_pkg.sv
// Shared pipeline definitions for the fetch redirect unit.
package fetch_redirect_unit_pkg;

  // Fetch FSM: RUN fetches sequentially, HALT freezes fetch after a bad target.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  // Sequential fetch stride in bytes.
  localparam logic [31:0] PC_INCR = 32'd4;

  // Low target bits that must be zero for an aligned 32-bit instruction.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // True when a redirect target is not word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return |(addr[1:0] & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_event_counter.sv
// Free-running event counter with enable and synchronous reset; wraps modulo 2^WIDTH.
module event_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count one per enabled edge; reset wins over enable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC sequencer: sequential fetch, execute-stage redirects with pipeline
// flush, sticky misaligned-target exception and branch/redirect statistics.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_br_tk,
  input  logic        ex_jump,
  input  logic [31:0] ex_target,
  output logic [31:0] f_pc,
  output logic        f_valid,
  output logic        flush_fd,
  output logic        flush_de,
  output logic        misalign_exc,
  output logic [31:0] exc_pc,
  output logic [31:0] br_count,
  output logic [31:0] tk_count
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic [31:0] r_pc;
  logic [31:0] r_exc_pc;
  logic        r_misalign;

  logic [31:0] w_next_pc;
  logic [31:0] w_next_exc_pc;
  logic        w_next_misalign;
  logic        w_valid;
  logic        w_flush;
  logic        w_br_en;
  logic        w_tk_en;
  logic        w_redirect;
  logic        w_bad_target;

  assign w_redirect   = ex_valid & (ex_br_tk | ex_jump);
  assign w_bad_target = is_misaligned(ex_target);

  // State and architectural registers; reset overrides any concurrent redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_exc_pc   <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_next_pc;
      r_exc_pc   <= w_next_exc_pc;
      r_misalign <= w_next_misalign;
    end
  end

  // Next-state, next-PC, flush and counter-enable decode.
  always_comb begin
    w_next_state    = r_state;
    w_next_pc       = r_pc;
    w_next_exc_pc   = r_exc_pc;
    w_next_misalign = r_misalign;
    w_valid         = 1'b0;
    w_flush         = 1'b0;
    w_br_en         = 1'b0;
    w_tk_en         = 1'b0;

    unique case (r_state)
      ST_RUN: begin
        w_valid = 1'b1;
        w_br_en = ex_valid & ex_is_branch;
        w_tk_en = w_redirect;
        if (w_redirect) begin
          w_flush = 1'b1;
          if (w_bad_target) begin
            w_next_state    = ST_HALT;
            w_next_misalign = 1'b1;
            w_next_exc_pc   = ex_target;
          end else begin
            w_next_pc = ex_target;
          end
        end else if (imem_ready && !stall) begin
          w_next_pc = r_pc + PC_INCR;
        end
      end
      ST_HALT: begin
        w_flush = 1'b1;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase

    // Reset is visible on the outputs while asserted, not only after the edge.
    if (reset) begin
      w_valid = 1'b0;
      w_flush = 1'b0;
      w_br_en = 1'b0;
      w_tk_en = 1'b0;
    end
  end

  event_counter #(.WIDTH(32)) u_br_count (
    .i_clk   (clock),
    .i_reset (reset),
    .i_en    (w_br_en),
    .o_count (br_count)
  );

  event_counter #(.WIDTH(32)) u_tk_count (
    .i_clk   (clock),
    .i_reset (reset),
    .i_en    (w_tk_en),
    .o_count (tk_count)
  );

  assign f_pc         = r_pc;
  assign f_valid      = w_valid;
  assign flush_fd     = w_flush;
  assign flush_de     = w_flush;
  assign misalign_exc = r_misalign;
  assign exc_pc       = r_exc_pc;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit with hand-computed expectations.
module tb_fetch_redirect_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        imem_ready;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_br_tk;
  logic        ex_jump;
  logic [31:0] ex_target;
  logic [31:0] f_pc;
  logic        f_valid;
  logic        flush_fd;
  logic        flush_de;
  logic        misalign_exc;
  logic [31:0] exc_pc;
  logic [31:0] br_count;
  logic [31:0] tk_count;

  int errors = 0;
  int checks = 0;

  fetch_redirect_unit #(.RESET_PC(32'h0100_0000)) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_br_tk     (ex_br_tk),
    .ex_jump      (ex_jump),
    .ex_target    (ex_target),
    .f_pc         (f_pc),
    .f_valid      (f_valid),
    .flush_fd     (flush_fd),
    .flush_de     (flush_de),
    .misalign_exc (misalign_exc),
    .exc_pc       (exc_pc),
    .br_count     (br_count),
    .tk_count     (tk_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs may be changed afterwards.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_br_tk     = 1'b0;
    ex_jump      = 1'b0;
    ex_target    = '0;
  endtask

  initial begin
    reset      = 1'b1;
    stall      = 1'b0;
    imem_ready = 1'b1;
    clear_ex();
    tick();
    tick();

    // Reset state while reset is held.
    chk("rst_pc",      f_pc,                  32'h0100_0000);
    chk("rst_valid",   {31'd0, f_valid},      32'd0);
    chk("rst_flush",   {30'd0, flush_fd, flush_de}, 32'd0);
    chk("rst_exc",     {31'd0, misalign_exc}, 32'd0);
    chk("rst_exc_pc",  exc_pc,                32'd0);
    chk("rst_br",      br_count,              32'd0);
    chk("rst_tk",      tk_count,              32'd0);

    // Reset overrides a simultaneous redirect.
    ex_valid  = 1'b1;
    ex_jump   = 1'b1;
    ex_target = 32'h0000_2000;
    #1;
    chk("rst_redir_flush", {30'd0, flush_fd, flush_de}, 32'd0);
    tick();
    chk("rst_redir_pc", f_pc,     32'h0100_0000);
    chk("rst_redir_tk", tk_count, 32'd0);
    clear_ex();

    // Release reset: first cycle presents RESET_PC with f_valid=1.
    reset = 1'b0;
    #1;
    chk("post_rst_pc",    f_pc,             32'h0100_0000);
    chk("post_rst_valid", {31'd0, f_valid}, 32'd1);
    tick();
    chk("seq_pc1", f_pc, 32'h0100_0004);
    tick();
    chk("seq_pc2", f_pc, 32'h0100_0008);
    tick();
    chk("seq_pc3", f_pc, 32'h0100_000C);

    // Re-reset and stall two cycles at 0x01000008.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("stall_start", f_pc, 32'h0100_0008);
    stall = 1'b1;
    tick();
    chk("stall_hold1", f_pc, 32'h0100_0008);
    tick();
    chk("stall_hold2", f_pc, 32'h0100_0008);
    stall = 1'b0;
    tick();
    chk("stall_release", f_pc, 32'h0100_000C);

    // Taken branch during stall: flush now, redirect next edge.
    ex_valid     = 1'b1;
    ex_is_branch = 1'b1;
    ex_br_tk     = 1'b1;
    ex_target    = 32'h0100_0100;
    stall        = 1'b1;
    #1;
    chk("br_flush_fd", {31'd0, flush_fd}, 32'd1);
    chk("br_flush_de", {31'd0, flush_de}, 32'd1);
    tick();
    clear_ex();
    stall = 1'b0;
    #1;
    chk("br_pc",       f_pc,     32'h0100_0100);
    chk("br_cnt",      br_count, 32'd1);
    chk("br_tk_cnt",   tk_count, 32'd1);
    chk("br_noflush",  {30'd0, flush_fd, flush_de}, 32'd0);

    // Taken flag ignored without ex_valid.
    ex_br_tk     = 1'b1;
    ex_is_branch = 1'b1;
    ex_target    = 32'h0000_0040;
    #1;
    chk("inv_flush", {30'd0, flush_fd, flush_de}, 32'd0);
    tick();
    clear_ex();
    chk("inv_pc", f_pc,     32'h0100_0104);
    chk("inv_br", br_count, 32'd1);
    chk("inv_tk", tk_count, 32'd1);

    // Aligned jump to the top word, then PC wraps to zero.
    ex_valid  = 1'b1;
    ex_jump   = 1'b1;
    ex_target = 32'hFFFF_FFFC;
    tick();
    clear_ex();
    chk("jmp_pc", f_pc,     32'hFFFF_FFFC);
    chk("jmp_br", br_count, 32'd1);
    chk("jmp_tk", tk_count, 32'd2);
    tick();
    chk("pc_wrap", f_pc, 32'd0);

    // Memory not ready: PC and valid held.
    imem_ready = 1'b0;
    tick();
    chk("nrdy_pc",    f_pc,             32'd0);
    chk("nrdy_valid", {31'd0, f_valid}, 32'd1);
    imem_ready = 1'b1;

    // Preload the redirect counter near the top, then wrap through it.
    force dut.u_tk_count.r_count = 32'hFFFF_FFFE;
    #1;
    release dut.u_tk_count.r_count;
    ex_valid  = 1'b1;
    ex_jump   = 1'b1;
    ex_target = 32'h0000_0010;
    tick();
    chk("tk_max", tk_count, 32'hFFFF_FFFF);
    ex_target = 32'h0000_0020;
    tick();
    clear_ex();
    chk("tk_wrap",    tk_count, 32'd0);
    chk("tk_wrap_pc", f_pc,     32'h0000_0020);

    // Misaligned jump target: flush, then HALT with sticky exception.
    ex_valid  = 1'b1;
    ex_jump   = 1'b1;
    ex_target = 32'h0100_0102;
    #1;
    chk("mis_flush", {30'd0, flush_fd, flush_de}, 32'd3);
    tick();
    clear_ex();
    #1;
    chk("mis_exc",    {31'd0, misalign_exc}, 32'd1);
    chk("mis_exc_pc", exc_pc,                32'h0100_0102);
    chk("mis_valid",  {31'd0, f_valid},      32'd0);
    chk("mis_pc",     f_pc,                  32'h0000_0020);
    chk("mis_tk",     tk_count,              32'd1);
    chk("halt_flush", {30'd0, flush_fd, flush_de}, 32'd3);

    // HALT ignores further redirects and branches.
    ex_valid     = 1'b1;
    ex_is_branch = 1'b1;
    ex_br_tk     = 1'b1;
    ex_target    = 32'h0000_0080;
    tick();
    clear_ex();
    chk("halt_pc",     f_pc,     32'h0000_0020);
    chk("halt_exc_pc", exc_pc,   32'h0100_0102);
    chk("halt_tk",     tk_count, 32'd1);
    chk("halt_br",     br_count, 32'd1);

    // Only reset leaves HALT.
    reset = 1'b1;
    tick();
    chk("rec_pc",     f_pc,                  32'h0100_0000);
    chk("rec_exc",    {31'd0, misalign_exc}, 32'd0);
    chk("rec_exc_pc", exc_pc,                32'd0);
    chk("rec_br",     br_count,              32'd0);
    reset = 1'b0;
    #1;
    chk("rec_valid", {31'd0, f_valid}, 32'd1);
    tick();
    chk("rec_adv", f_pc, 32'h0100_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
FETCH_REDIRECT_UNIT -- requirements
Module: fetch_redirect_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0100_0000, the fetch address loaded on reset.
REQ-002 SHALL have ports, one per line, as follows:
  clock  in  1  rising-edge clock
  reset  in  1  synchronous, active-high reset
  stall  in  1  hazard-unit request to hold the fetch PC
  imem_ready  in  1  instruction memory accepts the current fetch request
  ex_valid  in  1  execute-stage instruction is valid
  ex_is_branch  in  1  execute-stage instruction is a conditional branch
  ex_br_tk  in  1  branch-taken result from execute-stage branch control
  ex_jump  in  1  execute-stage instruction is JAL/JALR
  ex_target  in  32  execute-stage computed branch/jump target
  f_pc  out  32  current fetch address
  f_valid  out  1  fetch request valid
  flush_fd  out  1  squash the IF/ID pipeline register
  flush_de  out  1  squash the ID/EX pipeline register
  misalign_exc  out  1  sticky misaligned-target exception
  exc_pc  out  32  offending target address
  br_count  out  32  resolved conditional branches
  tk_count  out  32  redirects taken (branches plus jumps)
REQ-003 SHALL use one clock; reset is synchronous and active-high, and the ports are named clock and reset.

Function
REQ-004 SHALL implement a two-state FSM: RUN and HALT.
REQ-005 A redirect event SHALL be defined as ex_valid & (ex_br_tk | ex_jump); ex_br_tk and ex_jump SHALL be ignored while ex_valid=0.
REQ-006 In RUN:
  - f_valid SHALL be 1.
  - With no redirect event, f_pc SHALL advance by 4 at the clock edge iff imem_ready=1 and stall=0; otherwise f_pc SHALL hold.
REQ-007 On an aligned redirect event (ex_target[1:0]=2'b00) in RUN:
  - flush_fd and flush_de SHALL both be 1 combinationally in that same cycle.
  - f_pc SHALL load ex_target at the next edge, regardless of stall or imem_ready.
REQ-008 On a misaligned redirect event (ex_target[1:0]!=2'b00) in RUN:
  - flush_fd and flush_de SHALL be 1 in that same cycle.
  - At the next edge, the FSM SHALL go to HALT, misalign_exc SHALL be set to 1, exc_pc SHALL load ex_target, and f_pc SHALL hold.
REQ-009 In HALT:
  - f_valid SHALL be 0 and flush_fd and flush_de SHALL be 1.
  - f_pc, exc_pc, misalign_exc and both counters SHALL hold.
  - Only reset SHALL leave HALT.
REQ-010 Counters:
  - br_count SHALL increment by 1 on each edge where ex_valid & ex_is_branch holds in RUN.
  - tk_count SHALL increment by 1 on each edge where a redirect event (aligned or misaligned) holds in RUN.
  - Both counters SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-011 f_pc arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 yields 0.
REQ-012 Outside the cases in REQ-007 to REQ-009, flush_fd and flush_de SHALL be 0.
REQ-013 While imem_ready=0, f_pc and f_valid SHALL be held stable.

Reset
REQ-014 While reset=1, f_pc SHALL be RESET_PC, f_valid and flushes 0, misalign_exc 0, exc_pc 0, counters 0, FSM RUN, all taking effect at the edge.
REQ-015 Reset SHALL override every other input in the same cycle, including a simultaneous redirect event.
REQ-016 The first cycle after reset deasserts SHALL present f_pc=RESET_PC with f_valid=1.

Structure
REQ-017 The FSM state encoding, the PC increment constant (4), and the exception-alignment mask SHALL be defined in the shared pipeline package.
REQ-018 A single sub-module, event_counter (32-bit, with enable and synchronous reset), SHALL be instantiated twice, once for br_count and once for tk_count.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
  - Reset, then 3 cycles with imem_ready=1 and stall=0 -> f_pc sequence 0x01000000, 0x01000004, 0x01000008, 0x0100000C.
  - stall=1 for 2 cycles at f_pc=0x01000008 -> f_pc holds 0x01000008; advances to 0x0100000C after stall drops.
  - ex_valid=1, ex_is_branch=1, ex_br_tk=1, ex_target=0x01000100, with stall=1 -> flush_fd=flush_de=1 that cycle; f_pc=0x01000100 next; br_count=1, tk_count=1.
  - ex_br_tk=1 with ex_valid=0 -> no flush, f_pc advances by 4, counters unchanged.
  - ex_jump=1, ex_valid=1, ex_target=0x01000102 -> next cycle: misalign_exc=1, exc_pc=0x01000102, f_valid=0, f_pc frozen; assert reset -> f_pc=0x01000000, misalign_exc=0.
  - Preload tk_count=32'hFFFF_FFFF via forced redirects, then 1 more redirect -> tk_count=0.
